// File: rtl/ov7670_pkg.sv
// Shared OV7670 capture definitions: FSM encoding, default frame geometry
// and RGB565 field widths.
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_e;

  localparam int H_PIX_DEF   = 320;
  localparam int V_LINES_DEF = 240;
  localparam int ADDR_W_DEF  = 17;

  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int PIX_W  = R_W + G_W + B_W;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/ov7670_byte_packer.sv
// Pairs camera bytes into RGB565 pixels (first byte is the high half); a
// partial pixel is dropped when sampling stops. Write strobe is registered, 1 clk after byte two.
module ov7670_byte_packer
  import ov7670_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_i,
  input  logic              keep_i,
  input  logic [BYTE_W-1:0] d_i,
  output logic              pair_o,
  output logic              we_o,
  output logic [PIX_W-1:0]  dout_o
);

  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              we_q, we_d;
  logic [PIX_W-1:0]  dout_q, dout_d;

  assign pair_o = sample_i & phase_q;
  assign we_o   = we_q;
  assign dout_o = dout_q;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    dout_d  = dout_q;
    if (sample_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = d_i;
      end else if (keep_i) begin
        we_d   = 1'b1;
        dout_d = {hi_q, d_i};
      end
    end else begin
      // Any gap in sampling discards a lone high byte.
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: vsync-framed FSM, line/frame counters, RGB565 buffer writes.
// Define OV7670_CAPTURE_DECIMATE_EN to keep only even pixels of even lines (VGA -> H_PIX x V_LINES).
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              config_finished,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam int                COL_W     = $clog2(H_PIX + 1);
  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(H_PIX * V_LINES);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIX);

  state_e            state_q, state_d;
  logic              vsync_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q;

  logic              vs_fall, vs_rise, capturing, sof, sample;
  logic              pair, decim_keep, in_line, keep, we_w;
  logic [PIX_W-1:0]  dout_w;

  assign vs_fall   = vsync_q & ~vsync;
  assign vs_rise   = ~vsync_q & vsync;
  assign capturing = (state_q == ST_CAPTURE) && config_finished;
  assign sof       = (state_q == ST_WAIT_SOF) && config_finished && vs_fall;
  // A vsync transition wins over any href data in the same cycle.
  assign sample    = capturing && href && !vs_fall && !vs_rise;
  assign in_line   = decim_keep && (col_q < COL_MAX);
  assign keep      = in_line && (addr_q != PIX_TOTAL);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  logic href_q, line_odd_q, line_odd_d, pix_odd_q, pix_odd_d;

  assign decim_keep = !line_odd_q && !pix_odd_q;

  always_comb begin
    line_odd_d = line_odd_q;
    pix_odd_d  = pix_odd_q;
    if (sof) begin
      line_odd_d = 1'b0;
    end else if (capturing && href_q && !href) begin
      line_odd_d = !line_odd_q;
    end
    if (!sample) begin
      pix_odd_d = 1'b0;
    end else if (pair) begin
      pix_odd_d = !pix_odd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q     <= 1'b0;
      line_odd_q <= 1'b0;
      pix_odd_q  <= 1'b0;
    end else begin
      href_q     <= href;
      line_odd_q <= line_odd_d;
      pix_odd_q  <= pix_odd_d;
    end
  end
`else
  assign decim_keep = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (!config_finished) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (vs_fall) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (vs_rise) begin
            state_d      = ST_WAIT_SOF;
            frame_done_d = 1'b1;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d     = addr_q;
    overflow_d = overflow_q;
    col_d      = col_q;
    if (sof) begin
      addr_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (we_w) addr_d = addr_q + 1'b1;
      // A pixel that would have been stored but finds the buffer full.
      if (pair && in_line && (addr_q == PIX_TOTAL)) overflow_d = 1'b1;
    end
    if (!sample) begin
      col_d = '0;
    end else if (pair && in_line) begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b1;
      addr_q       <= '0;
      col_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      addr_q       <= addr_d;
      col_q        <= col_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d == ST_CAPTURE);
    end
  end

  ov7670_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (sample),
    .keep_i   (keep),
    .d_i      (d),
    .pair_o   (pair),
    .we_o     (we_w),
    .dout_o   (dout_w)
  );

  assign addr       = addr_q;
  assign dout       = dout_w;
  assign we         = we_w;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a small frame geometry.
module tb_ov7670_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int AW    = 6;
  localparam int TOTAL = H * V;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          config_finished = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    d = 8'h00;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we, frame_done, busy, overflow;

  ov7670_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .config_finished(config_finished),
    .vsync(vsync), .href(href), .d(d),
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   p;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  fd_cnt = 0;
  int  exp_fd = 0;
  int  m_addr = 0;
  int  m_line = 0;
  bit  m_ovf = 1'b0;
  bit  m_armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic bit keep_pix(input int ln, input int px);
    return !DECIM || ((ln % 2 == 0) && (px % 2 == 0));
  endfunction

  // Monitor: every write strobe is matched against the oldest expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: addr=%0d dout=0x%0h with no write expected", addr, dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(addr), 32'(mon_e.a));
          chk("wr_dout", 32'(dout), 32'(mon_e.p));
        end
      end
    end
  end

  task automatic sof();
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync   = 1'b0;
    m_addr  = 0;
    m_ovf   = 1'b0;
    m_line  = 0;
    m_armed = 1'b1;
    repeat (2) @(negedge clk);
    chk("sof_addr", 32'(addr), 0);
    chk("sof_overflow", 32'(overflow), 0);
  endtask

  // One href pulse of npix pixels, plus a lone extra byte when partial is set.
  task automatic line(input int npix, input bit partial, input int fixed);
    int kept;
    logic [15:0] px;
    kept = 0;
    for (int i = 0; i < npix; i++) begin
      px = (fixed < 0) ? 16'($urandom) : 16'(fixed);
      if (m_armed && keep_pix(m_line, i)) begin
        if (kept < H) begin
          if (m_addr < TOTAL) begin
            exp_q.push_back({AW'(m_addr), px});
            m_addr++;
          end else begin
            m_ovf = 1'b1;
          end
          kept++;
        end
      end
      @(negedge clk);
      href = 1'b1;
      d    = px[15:8];
      @(negedge clk);
      d    = px[7:0];
    end
    if (partial) begin
      @(negedge clk);
      href = 1'b1;
      d    = 8'($urandom);
    end
    @(negedge clk);
    href = 1'b0;
    d    = 8'($urandom);
    repeat (2) @(negedge clk);
    m_line++;
  endtask

  task automatic eof();
    @(negedge clk);
    if (m_armed) chk("busy_in_frame", 32'(busy), 1);
    vsync = 1'b1;
    if (m_armed) exp_fd++;
    repeat (3) @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt), 32'(exp_fd));
    chk("queue_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    if (m_armed) begin
      chk("end_addr", 32'(addr), 32'(m_addr));
      chk("end_overflow", 32'(overflow), 32'(m_ovf));
    end
    chk("busy_after_frame", 32'(busy), 0);
    m_armed = 1'b0;
  endtask

  initial begin
    logic [15:0] px;
    int nl;

    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    config_finished = 1'b1;
    repeat (3) @(negedge clk);

    // Two lines of four 0xF800 pixels.
    sof();
    line(4, 1'b0, 16'hF800);
    line(4, 1'b0, 16'hF800);
    eof();

    // Partial pixel then a clean line: phase must restart at the high byte.
    sof();
    line(1, 1'b1, -1);
    line(2, 1'b0, -1);
    eof();

    // Over-long line is clipped to H pixels.
    sof();
    line(H + 3, 1'b0, -1);
    line(3, 1'b0, -1);
    eof();

    // One line too many: overflow set, address pinned, cleared by next frame.
    sof();
    for (int l = 0; l < V + 1; l++) line(H, 1'b0, -1);
    eof();
    sof();
    line(2, 1'b0, -1);
    eof();

    // config_finished drops mid-pixel.
    sof();
    line(3, 1'b0, -1);
    px = 16'($urandom);
    @(negedge clk);
    href = 1'b1;
    d    = px[15:8];
    @(negedge clk);
    d = px[7:0];
    config_finished = 1'b0;
    @(negedge clk);
    chk("we_after_cfg_drop", 32'(we), 0);
    chk("busy_after_cfg_drop", 32'(busy), 0);
    href    = 1'b0;
    m_armed = 1'b0;
    vsync   = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_frame_done_after_cfg_drop", 32'(fd_cnt), 32'(exp_fd));
    chk("cfg_drop_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    config_finished = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a line; no writes until a fresh frame start.
    sof();
    line(3, 1'b0, -1);
    @(negedge clk);
    href  = 1'b1;
    d     = 8'($urandom);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_we", 32'(we), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_dout", 32'(dout), 0);
    href    = 1'b0;
    m_armed = 1'b0;
    chk("midrst_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    line(3, 1'b0, -1);
    eof();

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      sof();
      nl = $urandom_range(1, V + 2);
      for (int l = 0; l < nl; l++) line($urandom_range(1, H + 3), 1'($urandom_range(0, 1)), -1);
      eof();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
